// File: rtl/alu_mdu_pkg.sv
// ============================================================================
// Module   : mipspkg
// Brief    : Shared opcode/state types and width constant for alu_mdu.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mipspkg;

    localparam int DATAWIDTH = 32;

    typedef enum logic [4:0] {
        OP_AND   = 5'd0,
        OP_OR    = 5'd1,
        OP_SUM   = 5'd2,
        OP_SLT   = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_LUI   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_MULT  = 5'd8,
        OP_MULTU = 5'd9,
        OP_DIV   = 5'd10,
        OP_DIVU  = 5'd11,
        OP_MFHI  = 5'd12,
        OP_MFLO  = 5'd13,
        OP_MTHI  = 5'd14,
        OP_MTLO  = 5'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mdu_iter.sv
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative shift-add multiplier / restoring divider, one bit per
//            cycle, with sign fix-up applied on the final step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_start,
    input  logic         i_step,
    input  logic         i_is_div,
    input  logic         i_signed,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    localparam int CW = $clog2(W);

    // r_hi:r_lo is the partial product (multiply) or remainder:quotient (divide)
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_m;
    logic [CW-1:0]  r_cnt;
    logic           r_is_div;
    logic           r_neg_p;
    logic           r_neg_a;

    logic           w_neg_a;
    logic           w_neg_b;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W:0]     w_madd;
    logic [W:0]     w_shift;
    logic [W-1:0]   w_sub;
    logic           w_qbit;
    logic [W-1:0]   w_nxt_hi;
    logic [W-1:0]   w_nxt_lo;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fix;

    assign w_neg_a = i_signed & i_a[W-1];
    assign w_neg_b = i_signed & i_b[W-1];
    assign w_mag_a = w_neg_a ? (~i_a + W'(1)) : i_a;
    assign w_mag_b = w_neg_b ? (~i_b + W'(1)) : i_b;

    assign w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(W+1){1'b0}});
    assign w_shift = {r_hi, r_lo[W-1]};
    assign w_qbit  = (w_shift >= {1'b0, r_m});
    // When the quotient bit is set the true difference is below r_m, so W bits suffice
    assign w_sub   = w_shift[W-1:0] - r_m;

    always_comb begin
        w_nxt_hi = w_madd[W:1];
        w_nxt_lo = {w_madd[0], r_lo[W-1:1]};
        if (r_is_div) begin
            w_nxt_hi = w_qbit ? w_sub : w_shift[W-1:0];
            w_nxt_lo = {r_lo[W-2:0], w_qbit};
        end
    end

    assign w_prod     = {w_nxt_hi, w_nxt_lo};
    assign w_prod_fix = r_neg_p ? (~w_prod + (2*W)'(1)) : w_prod;

    always_comb begin
        o_hi = w_prod_fix[2*W-1:W];
        o_lo = w_prod_fix[W-1:0];
        if (r_is_div) begin
            o_hi = r_neg_a ? (~w_nxt_hi + W'(1)) : w_nxt_hi;
            o_lo = r_neg_p ? (~w_nxt_lo + W'(1)) : w_nxt_lo;
        end
    end

    assign o_done = i_step && (r_cnt == CW'(W-1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_p  <= 1'b0;
            r_neg_a  <= 1'b0;
        end else if (i_start) begin
            r_hi     <= '0;
            r_lo     <= i_is_div ? w_mag_a : w_mag_b;
            r_m      <= i_is_div ? w_mag_b : w_mag_a;
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_neg_p  <= w_neg_a ^ w_neg_b;
            r_neg_a  <= w_neg_a;
        end else if (i_step) begin
            r_hi     <= w_nxt_hi;
            r_lo     <= w_nxt_lo;
            r_cnt    <= o_done ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
// Module   : alu_mdu
// Brief    : Registered MIPS ALU with iterative MULT/DIV, HI/LO registers and
//            a valid/ready handshake for EX-stage stalls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mdu
    import mipspkg::*;
#(
    parameter int DATAWIDTH = mipspkg::DATAWIDTH,
    parameter int LUI_SHIFT = DATAWIDTH / 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [5:0]           alucont,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] result,
    output logic                 overflow,
    output logic                 illegal,
    output logic                 divzero,
    output logic                 busy
);

    localparam int W = DATAWIDTH;

    mdu_state_t     r_state;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_result;
    logic           r_out_valid;
    logic           r_overflow;
    logic           r_illegal;
    logic           r_divzero;

    mdu_state_t     w_state_nxt;
    logic [W-1:0]   w_hi_nxt;
    logic [W-1:0]   w_lo_nxt;
    logic [W-1:0]   w_result_nxt;
    logic           w_out_valid_nxt;
    logic           w_overflow_nxt;
    logic           w_illegal_nxt;
    logic           w_divzero_nxt;
    logic           w_mdu_start;
    logic           w_mdu_is_div;
    logic           w_mdu_step;
    logic           w_mdu_done;
    logic [W-1:0]   w_mdu_hi;
    logic [W-1:0]   w_mdu_lo;
    logic [W-1:0]   w_b_eff;
    logic [W-1:0]   w_sum;

    assign w_b_eff = alucont[5] ? ~b : b;
    assign w_sum   = a + w_b_eff + W'(alucont[5]);

    assign w_mdu_step   = (r_state != IDLE);
    assign w_mdu_is_div = (alucont[4:0] == OP_DIV) || (alucont[4:0] == OP_DIVU);

    mdu_iter #(
        .W (W)
    ) u_mdu_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_start  (w_mdu_start),
        .i_step   (w_mdu_step),
        .i_is_div (w_mdu_is_div),
        .i_signed (~alucont[0]),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_mdu_done),
        .o_hi     (w_mdu_hi),
        .o_lo     (w_mdu_lo)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_hi_nxt        = r_hi;
        w_lo_nxt        = r_lo;
        w_result_nxt    = r_result;
        w_out_valid_nxt = 1'b0;
        w_overflow_nxt  = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_divzero_nxt   = 1'b0;
        w_mdu_start     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_out_valid_nxt = 1'b1;
                    w_result_nxt    = '0;
                    case (alucont[4:0])
                        OP_AND:  w_result_nxt = a & b;
                        OP_OR:   w_result_nxt = a | b;
                        OP_SUM: begin
                            w_result_nxt   = w_sum;
                            w_overflow_nxt = (a[W-1] == w_b_eff[W-1]) && (w_sum[W-1] != a[W-1]);
                        end
                        OP_SLT:  w_result_nxt = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
                        OP_XOR:  w_result_nxt = a ^ b;
                        OP_NOR:  w_result_nxt = ~(a | b);
                        OP_LUI:  w_result_nxt = b << LUI_SHIFT;
                        OP_SLTU: w_result_nxt = {{(W-1){1'b0}}, a < b};
                        OP_MULT, OP_MULTU: begin
                            w_out_valid_nxt = 1'b0;
                            w_mdu_start     = 1'b1;
                            w_state_nxt     = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide-by-zero skips iteration and completes next cycle
                            if (b == '0) begin
                                w_lo_nxt      = '1;
                                w_hi_nxt      = a;
                                w_divzero_nxt = 1'b1;
                            end else begin
                                w_out_valid_nxt = 1'b0;
                                w_mdu_start     = 1'b1;
                                w_state_nxt     = DIV;
                            end
                        end
                        OP_MFHI: w_result_nxt = r_hi;
                        OP_MFLO: w_result_nxt = r_lo;
                        OP_MTHI: w_hi_nxt     = a;
                        OP_MTLO: w_lo_nxt     = a;
                        default: w_illegal_nxt = 1'b1;
                    endcase
                end
            end
            MUL, DIV: begin
                if (w_mdu_done) begin
                    w_hi_nxt        = w_mdu_hi;
                    w_lo_nxt        = w_mdu_lo;
                    w_result_nxt    = '0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
            r_divzero   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_result    <= w_result_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overflow  <= w_overflow_nxt;
            r_illegal   <= w_illegal_nxt;
            r_divzero   <= w_divzero_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;
    assign divzero   = r_divzero;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module   : tb_alu_mdu
// Brief    : Self-checking bench for alu_mdu: directed scenarios plus random
//            operations against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  alucont;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        illegal;
    logic        divzero;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    always #5 clk = ~clk;

    alu_mdu #(
        .DATAWIDTH (32),
        .LUI_SHIFT (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alucont   (alucont),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .illegal   (illegal),
        .divzero   (divzero),
        .busy      (busy)
    );

    // Called at posedge+1; returns at posedge+1 of the out_valid cycle (lat=-1 on timeout)
    task automatic do_op(input logic [5:0] c, input logic [31:0] ai, input logic [31:0] bi,
                         output logic [31:0] r, output logic ov, output logic ill,
                         output logic dz, output int lat, output int bcyc);
        int g = 0;
        alucont  = c;
        a        = ai;
        b        = bi;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 1;
        bcyc = 0;
        while (!out_valid && lat < 100) begin
            if (busy && !in_ready) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        r   = result;
        ov  = overflow;
        ill = illegal;
        dz  = divzero;
    endtask

    // Architectural reference: plain 64-bit arithmetic on the operands
    task automatic ref_model(input logic [5:0] c, input logic [31:0] ai, input logic [31:0] bi,
                             output logic [31:0] r, output logic ov, output logic ill,
                             output logic dz, output int lat);
        longint      sa, sb, s, q, rm;
        logic [63:0] p;
        sa = longint'($signed(ai));
        sb = longint'($signed(bi));
        r = '0; ov = 1'b0; ill = 1'b0; dz = 1'b0; lat = 1;
        case (c[4:0])
            5'd0:  r = ai & bi;
            5'd1:  r = ai | bi;
            5'd2: begin
                s  = c[5] ? sa - sb : sa + sb;
                r  = s[31:0];
                ov = (s != longint'($signed(s[31:0])));
            end
            5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  r = ai ^ bi;
            5'd5:  r = ~(ai | bi);
            5'd6:  r = {bi[15:0], 16'h0000};
            5'd7:  r = (ai < bi) ? 32'd1 : 32'd0;
            5'd8: begin
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0]; lat = 33;
            end
            5'd9: begin
                p = {32'h0, ai} * {32'h0, bi};
                m_hi = p[63:32]; m_lo = p[31:0]; lat = 33;
            end
            5'd10, 5'd11: begin
                if (bi == 32'h0) begin
                    dz = 1'b1; m_lo = 32'hFFFF_FFFF; m_hi = ai;
                end else begin
                    lat = 33;
                    if (c[0]) begin
                        m_lo = ai / bi; m_hi = ai % bi;
                    end else begin
                        q = sa / sb; rm = sa % sb;
                        m_lo = q[31:0]; m_hi = rm[31:0];
                    end
                end
            end
            5'd12: r = m_hi;
            5'd13: r = m_lo;
            5'd14: m_hi = ai;
            5'd15: m_lo = ai;
            default: ill = 1'b1;
        endcase
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] cs [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        int k = int'($urandom_range(0, 9));
        if (k < 5) return cs[k];
        return $urandom;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; alucont = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy, overflow, illegal, divzero, result} !== {6'b100000, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b flags=%b%b%b res=%h, expected rdy=1 others 0",
                     in_ready, out_valid, busy, overflow, illegal, divzero, result);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [31:0] r; logic ov, ill, dz; int lat, bc;
        logic [5:0]  cs [6] = '{6'b000010, 6'b000010, 6'b100010, 6'b000011, 6'b000111, 6'b000110};
        logic [31:0] as [6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0};
        logic [31:0] bs [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1234};
        logic [31:0] er [6] = '{32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h1234_0000};
        logic        eo [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(cs[i], as[i], bs[i], r, ov, ill, dz, lat, bc);
            n_vec++;
            if (r !== er[i] || ov !== eo[i] || ill !== 1'b0 || dz !== 1'b0 || lat != 1) begin
                n_err++;
                $display("FAIL alu_%0d: got res=%h ov=%b ill=%b dz=%b lat=%0d, expected res=%h ov=%b ill=0 dz=0 lat=1",
                         i, r, ov, ill, dz, lat, er[i], eo[i]);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [31:0] r, rh, rl; logic ov, ill, dz; int lat, bc, l2, b2;
        logic [5:0]  cs [4] = '{6'd8, 6'd9, 6'd10, 6'd11};
        logic [31:0] as [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h5};
        logic [31:0] bs [4] = '{32'h7, 32'hFFFF_FFFF, 32'h2, 32'h0};
        logic [31:0] eh [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h5};
        logic [31:0] el [4] = '{32'hFFFF_FFEB, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        int          elat [4] = '{33, 33, 33, 1};
        logic        edz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_op(cs[i], as[i], bs[i], r, ov, ill, dz, lat, bc);
            n_vec++;
            if (r !== 32'h0 || dz !== edz[i] || ov !== 1'b0 || lat != elat[i] || bc != elat[i] - 1) begin
                n_err++;
                $display("FAIL mdu_%0d_done: got res=%h dz=%b ov=%b lat=%0d busy=%0d, expected res=0 dz=%b ov=0 lat=%0d busy=%0d",
                         i, r, dz, ov, lat, bc, edz[i], elat[i], elat[i] - 1);
            end
            do_op(6'd12, 32'h0, 32'h0, rh, ov, ill, dz, l2, b2);
            do_op(6'd13, 32'h0, 32'h0, rl, ov, ill, dz, l2, b2);
            n_vec++;
            if (rh !== eh[i] || rl !== el[i]) begin
                n_err++;
                $display("FAIL mdu_%0d_hilo: got hi=%h lo=%h, expected hi=%h lo=%h", i, rh, rl, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_busy_hold();
        int c = 0;
        alucont = 6'd9; a = 32'h0001_0001; b = 32'h0001_0001; in_valid = 1'b1;
        @(posedge clk); #1;
        alucont = 6'd13; a = 32'h0; b = 32'h0;
        c = 1;
        while (!out_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        n_vec++;
        if (c != 33 || result !== 32'h0) begin
            n_err++;
            $display("FAIL hold_complete: got cycle=%0d res=%h, expected cycle=33 res=0", c, result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || result !== 32'h0002_0001) begin
            n_err++;
            $display("FAIL hold_mflo: got ov=%b res=%h, expected ov=1 res=00020001", out_valid, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        logic [31:0] r, rh, rl; logic ov, ill, dz; int lat, bc;
        do_op(6'd14, 32'hCAFE_F00D, 32'h0, r, ov, ill, dz, lat, bc);
        do_op(6'd15, 32'h0BAD_BEEF, 32'h0, r, ov, ill, dz, lat, bc);
        do_op(6'b010101, 32'h1234_5678, 32'h9ABC_DEF0, r, ov, ill, dz, lat, bc);
        n_vec++;
        if (r !== 32'h0 || ill !== 1'b1 || ov !== 1'b0 || dz !== 1'b0 || lat != 1) begin
            n_err++;
            $display("FAIL illegal_op: got res=%h ill=%b ov=%b dz=%b lat=%0d, expected res=0 ill=1 ov=0 dz=0 lat=1",
                     r, ill, ov, dz, lat);
        end
        do_op(6'd12, 32'h0, 32'h0, rh, ov, ill, dz, lat, bc);
        do_op(6'd13, 32'h0, 32'h0, rl, ov, ill, dz, lat, bc);
        n_vec++;
        if (rh !== 32'hCAFE_F00D || rl !== 32'h0BAD_BEEF) begin
            n_err++;
            $display("FAIL illegal_hilo: got hi=%h lo=%h, expected hi=cafef00d lo=0badbeef", rh, rl);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ex [3] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0};
        logic [5:0]  op [3] = '{6'd0, 6'd1, 6'd4};
        a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; in_valid = 1'b1;
        alucont = op[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) alucont = op[i+1];
            else in_valid = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || result !== ex[i]) begin
                n_err++;
                $display("FAIL b2b_%0d: got ov=%b res=%h, expected ov=1 res=%h", i, out_valid, result, ex[i]);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_tail: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rh, rl; logic ov, ill, dz; int lat, bc, seen = 0;
        alucont = 6'd8; a = 32'h1234_5678; b = 32'h8765_4321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_vec++;
        if ({in_ready, out_valid, busy, result} !== {3'b100, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_state: got rdy=%b ov=%b busy=%b res=%h, expected rdy=1 ov=0 busy=0 res=0",
                     in_ready, out_valid, busy, result);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_mid_stray: got %0d out_valid pulses, expected 0", seen);
        end
        do_op(6'd12, 32'h0, 32'h0, rh, ov, ill, dz, lat, bc);
        do_op(6'd13, 32'h0, 32'h0, rl, ov, ill, dz, lat, bc);
        n_vec++;
        if (rh !== 32'h0 || rl !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_hilo: got hi=%h lo=%h, expected 0/0", rh, rl);
        end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_random();
        logic [5:0]  c;
        logic [31:0] ra, rb, r, er, rh, rl;
        logic        ov, ill, dz, eov, eill, edz;
        int          lat, bc, elat, l2, b2;
        for (int i = 0; i < 150; i++) begin
            c  = 6'($urandom);
            ra = pick();
            rb = pick();
            ref_model(c, ra, rb, er, eov, eill, edz, elat);
            do_op(c, ra, rb, r, ov, ill, dz, lat, bc);
            n_vec++;
            if ({r, ov, ill, dz} !== {er, eov, eill, edz} || lat != elat || bc != elat - 1) begin
                n_err++;
                $display("FAIL rand_%0d op=%h a=%h b=%h: got res=%h ov=%b ill=%b dz=%b lat=%0d, expected res=%h ov=%b ill=%b dz=%b lat=%0d",
                         i, c, ra, rb, r, ov, ill, dz, lat, er, eov, eill, edz, elat);
            end
            if (c[4:2] == 3'b010) begin
                do_op(6'd12, 32'h0, 32'h0, rh, ov, ill, dz, l2, b2);
                do_op(6'd13, 32'h0, 32'h0, rl, ov, ill, dz, l2, b2);
                n_vec++;
                if (rh !== m_hi || rl !== m_lo) begin
                    n_err++;
                    $display("FAIL rand_%0d_hilo op=%h a=%h b=%h: got hi=%h lo=%h, expected hi=%h lo=%h",
                             i, c, ra, rb, rh, rl, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_busy_hold();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, clocked successor to the single-cycle MIPS ALU.
- Registers all ALU results and adds an iterative multiply/divide unit with architectural HI/LO registers.
- Uses a valid/ready handshake, so the pipeline EX stage can stall on multi-cycle MULT/DIV.
- Sits in the EX stage. Operands come from the ID/EX register; result/out_valid feed EX/MEM.

Parameters:
- DATAWIDTH, 32, operand, result, HI and LO width. Must be even and >= 8.
- LUI_SHIFT, DATAWIDTH/2, left-shift amount applied to b for LUI.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; high only in IDLE
- a  in  DATAWIDTH  operand 1 (rs)
- b  in  DATAWIDTH  operand 2 (rt/immediate)
- alucont  in  6  bit5 = subtract/invert b; bits4:0 = opcode
- out_valid  out  1  one-cycle pulse, result/overflow valid
- result  out  DATAWIDTH  registered result
- overflow  out  1  signed overflow of ADD/SUB; valid with out_valid
- illegal  out  1  unused opcode accepted; valid with out_valid
- divzero  out  1  DIV/DIVU with b==0; valid with out_valid
- busy  out  1  MUL or DIV iteration in progress

Behaviour:
- Reset (reset_n low at clk edge, even mid-operation):
  - state=IDLE; HI=LO=0; iteration counter=0.
  - result=0; out_valid=overflow=illegal=divzero=busy=0; in_ready=1 from the first post-reset cycle.
  - An in-flight MULT/DIV is discarded.
- Accept: an operation is accepted at a clk edge when in_valid && in_ready.
- Opcodes 0-6 (single-cycle): AND, OR, SUM, SLT (signed), XOR, NOR, LUI.
  - SUM = a + (bit5 ? ~b : b) + bit5.
  - LUI = b << LUI_SHIFT, truncated to DATAWIDTH.
  - Result registered; out_valid high the cycle after accept (latency 1). Unit stays IDLE, so back-to-back accepts are allowed.
- Opcode 7 SLTU: unsigned a<b, zero-extended to 1 or 0.
- Overflow: asserted only for opcode 2, when the operand MSBs (a and the inverted-or-not b) are equal and the sum MSB differs. It is 0 for every other opcode. Carry-out is never reported as overflow.
- Opcodes 8 MULT, 9 MULTU:
  - IDLE->MUL. Operands latched as magnitudes for signed, raw for unsigned.
  - Shift-add, one bit per cycle, DATAWIDTH cycles.
  - Then {HI,LO} = 2*DATAWIDTH-bit product, sign-corrected for MULT.
  - out_valid pulses, result=0, state->IDLE.
  - Latency from accept to out_valid is DATAWIDTH+1 cycles.
- Opcodes 10 DIV, 11 DIVU:
  - IDLE->DIV, restoring division, DATAWIDTH cycles, same latency as multiply.
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of a.
  - b==0: no iteration. Next cycle LO = all ones, HI = a, divzero=1, out_valid=1.
  - Signed most-negative / -1: LO = most-negative, HI = 0, overflow=0.
- Opcodes 12 MFHI, 13 MFLO: result = HI / LO, latency 1.
- Opcodes 14 MTHI, 15 MTLO: HI / LO = a at the edge after accept; out_valid pulses with result=0.
- Opcodes 16-31: result=0, illegal=1, out_valid=1, HI/LO unchanged.
- Busy window: busy=1 and in_ready=0 in MUL/DIV.
  - in_valid during that window is ignored and must be held by the producer.
  - MFHI/MFLO therefore always return the completed value.
- States: IDLE, MUL, DIV. The completion cycle returns to IDLE, so a new accept is possible in the same cycle out_valid pulses.
- All outputs are registered; no combinational path from inputs to outputs except none (in_ready depends on state only).

Decomposition:
- Shared package mipspkg:
  - DATAWIDTH constant.
  - typedef enum logic [4:0] alu_op_t with the opcodes above.
  - typedef enum logic [1:0] mdu_state_t {IDLE, MUL, DIV}.
- One sub-module: mdu_iter. It holds the shift-add/restoring datapath, counter and sign fix-up, with start/done signals and a hi/lo output.
- alu_mdu keeps the combinational ALU, the handshake and the HI/LO registers.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 (alucont=6'b000010) -> next cycle out_valid=1, result=0x80000000, overflow=1. Repeat with 0xFFFFFFFF + 1 -> result=0, overflow=0.
- SLT a=0xFFFFFFFE, b=0x00000001 -> result=1. SLTU on the same operands -> 0. LUI b=0x1234 -> 0x12340000.
- MULT a=0xFFFFFFFD (-3), b=7 -> in_ready low for 32 cycles, out_valid at cycle 33. Then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=5, b=0 -> 1-cycle latency, divzero=1, LO=0xFFFFFFFF, HI=5.
- Hold in_valid with MFLO during MULT busy -> not accepted until completion; MFLO returns the new product. Assert reset_n=0 at iteration 10 -> HI=LO=0, in_ready=1 next cycle, no out_valid.
- Opcode 5'b10101 -> illegal=1, result=0, HI/LO unchanged. Back-to-back AND/OR/XOR on consecutive cycles -> out_valid high three consecutive cycles with the correct results.
